// File: rtl/conv_layer_scheduler.sv
// Layer sequencer for the 3x3 convolution engine: runs one engine pass per kernel,
// stepping the kernel BRAM base and output bank between passes, with a per-wait watchdog.
module conv_layer_scheduler #(
  parameter int unsigned MAX_KERNELS       = 15,
  parameter int unsigned KERNEL_WORDS      = 9,
  parameter int unsigned ENGINE_RST_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES    = 32'd4000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] num_kernels,
  output logic       engine_reset,
  output logic       engine_kernel_read,
  input  logic       engine_kernel_done,
  output logic       engine_start,
  input  logic       engine_done,
  output logic [7:0] kernel_base,
  output logic [3:0] out_bank,
  output logic [3:0] pass_count,
  output logic       busy,
  output logic       layer_done,
  output logic       timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENG_RST = 3'd1;
  localparam logic [2:0] S_LOAD_K  = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
  localparam logic [2:0] S_ABORT   = 3'd7;

  localparam logic [3:0] NK_MAX = 4'(MAX_KERNELS);

  logic [2:0]  state_q, state_d;
  logic        start_q, start_edge;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  nk_q, nk_d, nk_in;
  logic [3:0]  pass_d, bank_d;
  logic [7:0]  base_d;
  logic        busy_d, done_d, terr_d, restart;

  always_comb begin
    start_edge = start & ~start_q;
    nk_in      = (num_kernels > NK_MAX) ? NK_MAX : num_kernels;
    state_d    = state_q;
    nk_d       = nk_q;
    pass_d     = pass_count;
    base_d     = kernel_base;
    bank_d     = out_bank;
    busy_d     = busy;
    done_d     = layer_done;
    terr_d     = timeout_err;
    restart    = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_ABORT;
      restart = 1'b1;
      busy_d  = 1'b0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start_edge) begin
            nk_d   = nk_in;
            pass_d = '0;
            base_d = '0;
            bank_d = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
            terr_d = 1'b0;
            if (nk_in == 4'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ENG_RST;
            end
          end
        end
        S_ENG_RST: if (cnt_q == ENGINE_RST_CYCLES - 1) state_d = S_LOAD_K;
        S_LOAD_K: begin
          // The awaited input wins over a watchdog expiry in the same cycle.
          if (engine_kernel_done) begin
            state_d = S_RUN;
          end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
            state_d = S_ERROR;
            terr_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        S_RUN: begin
          if (engine_done) begin
            state_d = S_NEXT;
          end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
            state_d = S_ERROR;
            terr_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        S_NEXT: begin
          pass_d = pass_count + 4'd1;
          if (pass_d == nk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            base_d  = kernel_base + 8'(KERNEL_WORDS);
            bank_d  = out_bank + 4'd1;
            state_d = S_ENG_RST;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_ABORT: if (cnt_q == ENGINE_RST_CYCLES - 1) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // One counter serves both the reset-hold length and the wait watchdog.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q inside {S_ENG_RST, S_LOAD_K, S_RUN, S_ABORT}) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      start_q            <= 1'b0;
      cnt_q              <= '0;
      nk_q               <= '0;
      pass_count         <= '0;
      kernel_base        <= '0;
      out_bank           <= '0;
      busy               <= 1'b0;
      layer_done         <= 1'b0;
      timeout_err        <= 1'b0;
      engine_reset       <= 1'b0;
      engine_kernel_read <= 1'b0;
      engine_start       <= 1'b0;
    end else begin
      state_q            <= state_d;
      start_q            <= start;
      cnt_q              <= cnt_d;
      nk_q               <= nk_d;
      pass_count         <= pass_d;
      kernel_base        <= base_d;
      out_bank           <= bank_d;
      busy               <= busy_d;
      layer_done         <= done_d;
      timeout_err        <= terr_d;
      engine_reset       <= state_d inside {S_ENG_RST, S_ERROR, S_ABORT};
      engine_kernel_read <= (state_d == S_LOAD_K);
      engine_start       <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: engine model, phase-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized layers.
module tb_conv_layer_scheduler;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset_n, start, abort;
  logic [3:0] num_kernels;
  logic       engine_reset, engine_kernel_read, engine_start;
  logic       engine_kernel_done = 1'b0;
  logic       engine_done = 1'b0;
  logic [7:0] kernel_base;
  logic [3:0] out_bank, pass_count;
  logic       busy, layer_done, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_layer_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .num_kernels(num_kernels),
    .engine_reset(engine_reset), .engine_kernel_read(engine_kernel_read),
    .engine_kernel_done(engine_kernel_done), .engine_start(engine_start),
    .engine_done(engine_done), .kernel_base(kernel_base), .out_bank(out_bank),
    .pass_count(pass_count), .busy(busy), .layer_done(layer_done), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: kernel_done / done rise a set number of cycles after their triggers.
  bit rand_eng = 1'b0;
  bit fix_hang = 1'b0;
  int fix_kd = 12, fix_dn = 50;
  int kd_lat = 12, dn_lat = 50, kc = 0, dc = 0;
  bit hang_r = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!reset_n || engine_reset) begin
      engine_kernel_done = 1'b0;
      engine_done = 1'b0;
      kc = 0;
      dc = 0;
      kd_lat = rand_eng ? int'($urandom_range(1, 15)) : fix_kd;
      dn_lat = rand_eng ? int'($urandom_range(1, 40)) : fix_dn;
      hang_r = rand_eng && ($urandom_range(0, 7) == 0);
    end else begin
      if (engine_kernel_read && !engine_kernel_done) begin
        kc++;
        if (kc >= kd_lat) engine_kernel_done = 1'b1;
      end
      if (engine_start && !engine_done && !fix_hang && !hang_r) begin
        dc++;
        if (dc >= dn_lat) engine_done = 1'b1;
      end
    end
  end

  // Reference model: layer progress as phases with countdowns.
  typedef enum {P_IDLE, P_RST, P_LOAD, P_RUN, P_NEXT, P_DONE, P_ERR, P_ABT} ph_t;
  ph_t ph = P_IDLE;
  int  left = 0, wd = 0, m_nk = 0, m_pass = 0, m_kb = 0, m_ob = 0;
  bit  m_busy = 0, m_ld = 0, m_te = 0, m_sp = 0, edge_s;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      ph = P_IDLE; left = 0; wd = 0; m_nk = 0; m_pass = 0; m_kb = 0; m_ob = 0;
      m_busy = 0; m_ld = 0; m_te = 0; m_sp = 0;
    end else begin
      edge_s = start && !m_sp;
      m_sp = start;
      if (abort && ph != P_IDLE) begin
        ph = P_ABT; left = 2; m_busy = 0; m_te = 0;
      end else begin
        case (ph)
          P_IDLE, P_ERR: if (edge_s) begin
            m_nk = int'(num_kernels); m_pass = 0; m_kb = 0; m_ob = 0;
            m_busy = 1; m_ld = 0; m_te = 0;
            if (m_nk == 0) begin ph = P_DONE; m_ld = 1; end
            else begin ph = P_RST; left = 2; end
          end
          P_RST: begin left--; if (left == 0) begin ph = P_LOAD; wd = 0; end end
          P_LOAD: if (engine_kernel_done) begin ph = P_RUN; wd = 0; end
                  else begin wd++; if (wd == TO) begin ph = P_ERR; m_te = 1; m_busy = 0; end end
          P_RUN: if (engine_done) ph = P_NEXT;
                 else begin wd++; if (wd == TO) begin ph = P_ERR; m_te = 1; m_busy = 0; end end
          P_NEXT: begin
            m_pass++;
            if (m_pass == m_nk) begin ph = P_DONE; m_ld = 1; end
            else begin m_kb += 9; m_ob++; ph = P_RST; left = 2; end
          end
          P_DONE: begin m_busy = 0; ph = P_IDLE; end
          P_ABT: begin left--; if (left == 0) ph = P_IDLE; end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("engine_reset", 32'(engine_reset), 32'(ph inside {P_RST, P_ERR, P_ABT}));
    check("engine_kernel_read", 32'(engine_kernel_read), 32'(ph == P_LOAD));
    check("engine_start", 32'(engine_start), 32'(ph == P_RUN));
    check("kernel_base", 32'(kernel_base), m_kb);
    check("out_bank", 32'(out_bank), m_ob);
    check("pass_count", 32'(pass_count), m_pass);
    check("busy", 32'(busy), 32'(m_busy));
    check("layer_done", 32'(layer_done), 32'(m_ld));
    check("timeout_err", 32'(timeout_err), 32'(m_te));
  end

  task automatic wait_layer_done(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (layer_done) begin ok = 1'b1; break; end
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic restart_start(input logic [3:0] nk);
    start = 1'b0;
    @(negedge clk);
    num_kernels = nk;
    start = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench timeout");
  end

  int  nrd, nrst, rlen, cnt, rises;
  bit  prev, got;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; num_kernels = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_engine_reset", 32'(engine_reset), 0);
    check("rst_kernel_base", 32'(kernel_base), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-pass layer, start held high afterwards.
    num_kernels = 4'd3; start = 1'b1;
    nrd = 0; nrst = 0; rlen = 0; prev = 1'b0; got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (engine_kernel_read && !prev) begin
        check("t1_kernel_base", 32'(kernel_base), nrd * 9);
        check("t1_out_bank", 32'(out_bank), nrd);
        nrd++;
      end
      prev = engine_kernel_read;
      if (engine_reset) rlen++;
      else if (rlen != 0) begin check("t1_reset_len", rlen, 2); nrst++; rlen = 0; end
      check("t1_busy_high", 32'(busy), 1);
      if (layer_done) begin got = 1'b1; break; end
    end
    check("t1_done_seen", 32'(got), 1);
    check("t1_loads", nrd, 3);
    check("t1_reset_pulses", nrst, 3);
    check("t1_pass_count", 32'(pass_count), 3);
    check("t1_final_bank", 32'(out_bank), 2);
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 0);
    check("t1_layer_done", 32'(layer_done), 1);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy) cnt++; end
    check("t1_no_relaunch", cnt, 0);

    // Zero kernels.
    restart_start(4'd0);
    cnt = 0; rises = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) cnt++;
      if (engine_start || engine_kernel_read) rises++;
    end
    check("t2_busy_cycles", cnt, 1);
    check("t2_no_engine", rises, 0);
    check("t2_layer_done", 32'(layer_done), 1);

    // Watchdog expiry in RUN, then a clean restart.
    fix_hang = 1'b1;
    restart_start(4'd2);
    got = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (engine_start) begin got = 1'b1; break; end
    end
    check("t3_run_entered", 32'(got), 1);
    cnt = 0;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (timeout_err) begin cnt = c; break; end
    end
    check("t3_timeout_latency", cnt, TO);
    check("t3_engine_start_low", 32'(engine_start), 0);
    check("t3_busy_low", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("t3_reset_held", 32'(engine_reset), 1);
    fix_hang = 1'b0;
    restart_start(4'd1);
    @(negedge clk);
    check("t3_err_cleared", 32'(timeout_err), 0);
    check("t3_restart_busy", 32'(busy), 1);
    check("t3_restart_pass", 32'(pass_count), 0);
    wait_layer_done("t3_restart_done");
    check("t3_restart_count", 32'(pass_count), 1);

    // Abort during the second pass's run.
    restart_start(4'd4);
    rises = 0; prev = 1'b0; got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (engine_start && !prev) rises++;
      prev = engine_start;
      if (rises == 2) begin got = 1'b1; break; end
    end
    check("t4_second_run", 32'(got), 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_start_dropped", 32'(engine_start), 0);
    check("t4_reset_1", 32'(engine_reset), 1);
    @(negedge clk);
    check("t4_reset_2", 32'(engine_reset), 1);
    @(negedge clk);
    check("t4_reset_off", 32'(engine_reset), 0);
    check("t4_pass_count", 32'(pass_count), 1);
    check("t4_layer_done", 32'(layer_done), 0);
    check("t4_busy", 32'(busy), 0);

    // Second start edge mid-run is ignored; held start does not relaunch.
    restart_start(4'd2);
    repeat (30) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    rises = 0; prev = 1'b1; got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
      if (layer_done) got = 1'b1;
      if (got && c > 400) break;
    end
    check("t5_done", 32'(got), 1);
    check("t5_single_layer", rises, 0);
    check("t5_pass_count", 32'(pass_count), 2);

    // Asynchronous reset in the middle of a kernel load.
    restart_start(4'd2);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (engine_kernel_read) begin got = 1'b1; break; end
    end
    check("t6_load_entered", 32'(got), 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_kernel_read_0", 32'(engine_kernel_read), 0);
    check("t6_engine_reset_0", 32'(engine_reset), 0);
    check("t6_busy_0", 32'(busy), 0);
    check("t6_bases_0", 32'({kernel_base, out_bank, pass_count}), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_busy", 32'(busy), 0);
    num_kernels = 4'd1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_restart_busy", 32'(busy), 1);
    wait_layer_done("t6_done");

    // Randomized layers with random latencies, hangs and aborts.
    rand_eng = 1'b1;
    for (int l = 0; l < 30; l++) begin
      start = 1'b0;
      num_kernels = 4'($urandom_range(0, 5));
      repeat ($urandom_range(1, 2)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        num_kernels = 4'($urandom_range(0, 15));
        abort = ($urandom_range(0, 299) == 0);
        if (!busy) begin got = 1'b1; break; end
      end
      abort = 1'b0;
      check("rand_layer_ends", 32'(got), 1);
      repeat (3) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Sequences the 3x3 convolution engine over several kernels (output channels) to complete one layer.
- Per pass it resets the engine, points it at one kernel in kernel BRAM, triggers the kernel load, then triggers the full-frame run, and steps to the next output bank when the run finishes.
- Sits between the host/top-level control and the engine's start / kernel_read / done handshake.

Parameters:
- MAX_KERNELS, 15: largest accepted pass count; num_kernels is 4 bits wide.
- KERNEL_WORDS, 9: kernel BRAM words per kernel; kernel_base advances by this amount each pass.
- ENGINE_RST_CYCLES, 2: number of cycles engine_reset is held high before each pass and on abort.
- TIMEOUT_CYCLES, 32'd4000000: watchdog limit for each wait state. It covers 222x222 patches at roughly 30 cycles each, with margin.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level input; a layer starts on its rising edge.
- abort  in  1  synchronous abort, sampled every cycle.
- num_kernels  in  4  passes per layer; latched when start is accepted.
- engine_reset  out  1  active-high synchronous reset to the engine.
- engine_kernel_read  out  1  held high while the kernel load is in progress.
- engine_kernel_done  in  1  engine's kernel_read_complete (level).
- engine_start  out  1  held high until engine_done is seen.
- engine_done  in  1  engine done (level; sticky until engine reset).
- kernel_base  out  8  kernel BRAM base address for the current pass, equal to pass*KERNEL_WORDS.
- out_bank  out  4  output BRAM bank select, equal to the current pass index.
- pass_count  out  4  number of passes completed.
- busy  out  1  high from start acceptance until DONE or IDLE is reached.
- layer_done  out  1  sticky; cleared by the next accepted start.
- timeout_err  out  1  sticky; cleared by the next accepted start or by abort.

Behaviour:
- Reset values (reset_n low, asynchronous): state IDLE, and all outputs 0.
- Edge detection: start_q is a registered copy of start. A rising edge is start & ~start_q.
- States: IDLE, ENG_RST, LOAD_K, RUN, NEXT, DONE, ERROR, ABORT. Registered Moore outputs.
- IDLE:
  - A start rising edge latches num_kernels and clears layer_done, timeout_err, pass_count, kernel_base and out_bank.
  - It then sets busy=1.
  - If num_kernels==0, go to DONE; otherwise go to ENG_RST.
  - start edges are ignored in every state except IDLE and ERROR.
- ENG_RST: engine_reset=1 for exactly ENGINE_RST_CYCLES cycles, then go to LOAD_K.
- LOAD_K:
  - engine_kernel_read=1, and kernel_base is stable throughout.
  - When engine_kernel_done=1: drop engine_kernel_read and go to RUN.
  - The earliest transition is the cycle after entry.
- RUN:
  - engine_start=1.
  - When engine_done=1: drop engine_start and go to NEXT.
- Watchdog:
  - A 32-bit counter clears on entry to LOAD_K or RUN and increments every cycle in those states.
  - When count==TIMEOUT_CYCLES-1 and the awaited input is still low, go to ERROR.
  - If the input arrives in the same cycle the limit is hit, the input wins.
- NEXT (one cycle): pass_count+=1.
  - If the new pass_count equals the latched num_kernels, go to DONE.
  - Otherwise kernel_base+=KERNEL_WORDS, out_bank+=1, and go to ENG_RST.
  - kernel_base is 8 bits; 15*9=135 fits, so no wrap is possible.
- DONE (one cycle): layer_done=1, busy=0, then go to IDLE. out_bank and pass_count hold their final values.
- ERROR:
  - timeout_err=1, busy=0, and all engine controls low except engine_reset=1 (held).
  - A start rising edge clears the error and behaves as an IDLE start.
  - abort goes to ABORT.
- ABORT:
  - Taken on abort=1 from any state except IDLE; abort has priority over all other transitions.
  - engine_reset=1 for ENGINE_RST_CYCLES cycles, then go to IDLE.
  - Clears busy and timeout_err. layer_done stays 0, and pass_count keeps its partial value.
  - abort in IDLE has no effect.
- Asynchronous reset mid-pass: all outputs go to 0 immediately, engine_reset is deasserted, and the engine's own reset is the responsibility of the top level.
- No combinational path from any input to any output.

Test Plan:
- num_kernels=3, engine model with kernel_done 12 cycles and done 50 cycles after its triggers:
  - Expect 3 passes with kernel_base 0/9/18 and out_bank 0/1/2.
  - Expect engine_reset pulses of 2 cycles before each pass.
  - Expect layer_done=1 and pass_count=3; busy is high throughout and drops the cycle after DONE.
- num_kernels=0 with a start edge: busy for 1 cycle, layer_done=1, no engine_start or engine_kernel_read ever.
- TIMEOUT_CYCLES=100 and engine_done never asserted: timeout_err=1 exactly 100 cycles after RUN entry, and engine_reset held. A new start edge restarts cleanly from pass 0.
- abort during pass 2 RUN of num_kernels=4:
  - engine_start drops the next cycle and engine_reset is high for 2 cycles, then IDLE.
  - pass_count=1, layer_done=0, busy=0.
- start held high through the whole layer, plus a second start edge mid-run: only one layer executes, and a new layer needs start to go low then high.
- reset_n pulled low asynchronously mid-LOAD_K: all outputs 0 before the next clock edge, and state is IDLE after release.
